// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_RMW} state_t;
  typedef enum logic {GNT_IF, GNT_LS} grant_t;

  localparam logic [3:0] WSTRB_FULL = 4'hF;

endpackage

// File: rtl/byte_merge.sv
// Byte-lane merge for read-modify-write: each lane takes the new byte when its strobe is set.
module byte_merge (
  input  logic [31:0] old_data,
  input  logic [31:0] new_data,
  input  logic [3:0]  strb,
  output logic [31:0] merged
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = strb[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store access to a single-ported word memory, one transaction
// per cycle; sub-word stores become a two-cycle read-modify-write.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter bit DATA_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  input  logic [3:0]        ls_wstrb,
  output logic              ls_ready,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t state, state_next;
  grant_t last_grant, grant;
  logic   gnt_valid, if_acc, ls_acc;
  logic   ls_full, ls_null, ls_partial;

  logic [ADDR_W-1:0] if_idx, ls_idx, rmw_idx;
  logic [31:0]       rmw_wdata, rmw_old, merged;
  logic [3:0]        rmw_strb;

  // Byte offset and high address bits are deliberately dropped: addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              ls_addr[31:ADDR_W+2], ls_addr[1:0]};

  assign if_idx = if_addr[ADDR_W+1:2];
  assign ls_idx = ls_addr[ADDR_W+1:2];

  assign ls_full    = ls_we && (ls_wstrb == WSTRB_FULL);
  assign ls_null    = ls_we && (ls_wstrb == 4'h0);
  assign ls_partial = ls_we && !ls_full && !ls_null;

  byte_merge u_merge (
    .old_data (rmw_old),
    .new_data (rmw_wdata),
    .strb     (rmw_strb),
    .merged   (merged)
  );

  always_comb begin
    gnt_valid = 1'b0;
    grant     = GNT_IF;
    if (state == ARB_IDLE) begin
      if (if_req && ls_req) begin
        gnt_valid = 1'b1;
        if (DATA_PRIORITY || last_grant == GNT_IF) grant = GNT_LS;
        else                                       grant = GNT_IF;
      end else if (ls_req) begin
        gnt_valid = 1'b1;
        grant     = GNT_LS;
      end else if (if_req) begin
        gnt_valid = 1'b1;
      end
    end
  end

  assign if_acc = gnt_valid && (grant == GNT_IF);
  assign ls_acc = gnt_valid && (grant == GNT_LS);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: if (ls_acc && ls_partial) state_next = ARB_RMW;
      ARB_RMW:  state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    if_ready  = 1'b0;
    ls_ready  = 1'b0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_raddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state)
      ARB_IDLE: begin
        if_ready = if_acc;
        ls_ready = ls_acc;
        if (if_acc) begin
          mem_ren   = 1'b1;
          mem_raddr = if_idx;
        end else if (ls_acc) begin
          if (!ls_we || ls_partial) begin
            mem_ren   = 1'b1;
            mem_raddr = ls_idx;
          end else if (ls_full) begin
            mem_wen   = 1'b1;
            mem_waddr = ls_idx;
            mem_wdata = ls_wdata;
          end
        end
      end
      ARB_RMW: begin
        mem_wen   = 1'b1;
        mem_waddr = rmw_idx;
        mem_wdata = merged;
      end
      default: ;
    endcase
  end

  // NOTE: the RMW holding registers are reset too, so a reset mid-RMW leaves no stale
  // write data that a later state could expose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_IF;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      ls_rvalid  <= 1'b0;
      ls_rdata   <= '0;
      rmw_idx    <= '0;
      rmw_wdata  <= '0;
      rmw_strb   <= '0;
      rmw_old    <= '0;
    end else begin
      if_rvalid <= if_acc;
      ls_rvalid <= (ls_acc && !ls_partial) || (state == ARB_RMW);
      if (if_acc) begin
        last_grant <= GNT_IF;
        if_rdata   <= mem_rdata;
      end
      if (ls_acc) begin
        last_grant <= GNT_LS;
        ls_rdata   <= ls_we ? 32'h0 : mem_rdata;
        if (ls_partial) begin
          rmw_idx   <= ls_idx;
          rmw_wdata <= ls_wdata;
          rmw_strb  <= ls_wstrb;
          rmw_old   <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus RMW, contention and reset sequences.
module tb_mem_arbiter;

  logic        clk, rst_n;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [3:0]  ls_wstrb;

  logic        if_ready, if_rvalid, ls_ready, ls_rvalid, mem_wen, mem_ren;
  logic [31:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_waddr, mem_raddr;

  logic        p1_if_ready, p1_if_rvalid, p1_ls_ready, p1_ls_rvalid, p1_mem_wen, p1_mem_ren;
  logic [31:0] p1_if_rdata, p1_ls_rdata, p1_mem_wdata, p1_mem_rdata;
  logic [15:0] p1_mem_waddr, p1_mem_raddr;

  logic [31:0] mem [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [31:0] pl_data;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_PRIORITY(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_PRIORITY(1'b1)) u_dut_prio (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(p1_if_ready),
    .if_rvalid(p1_if_rvalid), .if_rdata(p1_if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_ready(p1_ls_ready), .ls_rvalid(p1_ls_rvalid), .ls_rdata(p1_ls_rdata),
    .mem_wen(p1_mem_wen), .mem_ren(p1_mem_ren), .mem_waddr(p1_mem_waddr),
    .mem_raddr(p1_mem_raddr), .mem_wdata(p1_mem_wdata), .mem_rdata(p1_mem_rdata)
  );

  assign mem_rdata    = mem[mem_raddr];
  assign p1_mem_rdata = {16'h0, p1_mem_raddr};

  always @(posedge clk) begin
    if (mem_wen)    mem[mem_waddr] <= mem_wdata;
    else if (pl_en) mem[pl_addr]   <= pl_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        if_ready;
    logic        ls_ready;
    logic        ren;
    logic        wen;
    logic [15:0] raddr;
    logic [15:0] waddr;
    logic [31:0] wdata;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    clear_inputs();

    //            if_req if_addr     ls_req we ls_addr   ls_wdata       strb  ifr lsr ren wen raddr  waddr  wdata          ifv if_rdata       lsv ls_rdata
    vecs[0]  = '{0, 32'h0,       0, 0, 32'h0,  32'h0,         4'h0, 0, 0, 0, 0, 16'h0,  16'h0,  32'h0,         0, 32'h0,         0, 32'h0};
    vecs[1]  = '{1, 32'h14,      0, 0, 32'h0,  32'h0,         4'h0, 1, 0, 1, 0, 16'h5,  16'h0,  32'h0,         0, 32'h0,         0, 32'h0};
    vecs[2]  = '{0, 32'h0,       1, 1, 32'h40, 32'h1234_5678, 4'hF, 0, 1, 0, 1, 16'h0,  16'h10, 32'h1234_5678, 1, 32'hDEAD_BEEF, 0, 32'h0};
    vecs[3]  = '{0, 32'h0,       1, 0, 32'h40, 32'h0,         4'h0, 0, 1, 1, 0, 16'h10, 16'h0,  32'h0,         0, 32'h0,         1, 32'h0};
    vecs[4]  = '{0, 32'h0,       0, 0, 32'h0,  32'h0,         4'h0, 0, 0, 0, 0, 16'h0,  16'h0,  32'h0,         0, 32'h0,         1, 32'h1234_5678};
    vecs[5]  = '{0, 32'h0,       1, 1, 32'h8,  32'hFFFF_FFFF, 4'h0, 0, 1, 0, 0, 16'h0,  16'h0,  32'h0,         0, 32'h0,         0, 32'h0};
    vecs[6]  = '{1, 32'h4_0008,  0, 0, 32'h0,  32'h0,         4'h0, 1, 0, 1, 0, 16'h2,  16'h0,  32'h0,         0, 32'h0,         1, 32'h0};
    vecs[7]  = '{0, 32'h0,       0, 0, 32'h0,  32'h0,         4'h0, 0, 0, 0, 0, 16'h0,  16'h0,  32'h0,         1, 32'h2222_2222, 0, 32'h0};
    vecs[8]  = '{1, 32'h14,      1, 0, 32'h8,  32'h0,         4'h0, 0, 1, 1, 0, 16'h2,  16'h0,  32'h0,         0, 32'h0,         0, 32'h0};
    vecs[9]  = '{1, 32'h14,      0, 0, 32'h0,  32'h0,         4'h0, 1, 0, 1, 0, 16'h5,  16'h0,  32'h0,         0, 32'h0,         1, 32'h2222_2222};
    vecs[10] = '{0, 32'h0,       0, 0, 32'h0,  32'h0,         4'h0, 0, 0, 0, 0, 16'h0,  16'h0,  32'h0,         1, 32'hDEAD_BEEF, 0, 32'h0};

    tick();
    preload(16'h5,  32'hDEAD_BEEF);
    preload(16'h10, 32'hAABB_CCDD);
    preload(16'h2,  32'h2222_2222);

    @(negedge clk);
    check("rst if_ready",  {31'b0, if_ready},  32'h0);
    check("rst ls_ready",  {31'b0, ls_ready},  32'h0);
    check("rst mem_wen",   {31'b0, mem_wen},   32'h0);
    check("rst mem_ren",   {31'b0, mem_ren},   32'h0);
    check("rst if_rvalid", {31'b0, if_rvalid}, 32'h0);
    check("rst ls_rvalid", {31'b0, ls_rvalid}, 32'h0);
    check("rst if_rdata",  if_rdata,           32'h0);
    check("rst ls_rdata",  ls_rdata,           32'h0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      ls_req = vecs[i].ls_req; ls_we = vecs[i].ls_we; ls_addr = vecs[i].ls_addr;
      ls_wdata = vecs[i].ls_wdata; ls_wstrb = vecs[i].ls_wstrb;
      @(negedge clk);
      check($sformatf("v%0d if_ready", i), {31'b0, if_ready}, {31'b0, vecs[i].if_ready});
      check($sformatf("v%0d ls_ready", i), {31'b0, ls_ready}, {31'b0, vecs[i].ls_ready});
      check($sformatf("v%0d mem_ren", i),  {31'b0, mem_ren},  {31'b0, vecs[i].ren});
      check($sformatf("v%0d mem_wen", i),  {31'b0, mem_wen},  {31'b0, vecs[i].wen});
      if (vecs[i].ren) check($sformatf("v%0d mem_raddr", i), {16'b0, mem_raddr}, {16'b0, vecs[i].raddr});
      if (vecs[i].wen) begin
        check($sformatf("v%0d mem_waddr", i), {16'b0, mem_waddr}, {16'b0, vecs[i].waddr});
        check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].wdata);
      end
      check($sformatf("v%0d if_rvalid", i), {31'b0, if_rvalid}, {31'b0, vecs[i].if_rvalid});
      check($sformatf("v%0d ls_rvalid", i), {31'b0, ls_rvalid}, {31'b0, vecs[i].ls_rvalid});
      if (vecs[i].if_rvalid) check($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].if_rdata);
      if (vecs[i].ls_rvalid) check($sformatf("v%0d ls_rdata", i), ls_rdata, vecs[i].ls_rdata);
      tick();
    end
    clear_inputs();
    check("null store word 2", mem[16'h2], 32'h2222_2222);

    // Partial store: read in N, merged write in N+1 with both readies low, ack in N+2.
    preload(16'h10, 32'hAABB_CCDD);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h0000_EE00; ls_wstrb = 4'b0010;
    @(negedge clk);
    check("rmw N ls_ready",  {31'b0, ls_ready}, 32'h1);
    check("rmw N mem_ren",   {31'b0, mem_ren},  32'h1);
    check("rmw N mem_raddr", {16'b0, mem_raddr}, 32'h10);
    check("rmw N mem_wen",   {31'b0, mem_wen},  32'h0);
    tick();
    if_req = 1'b1; if_addr = 32'h14;
    ls_we = 1'b0; ls_addr = 32'h8; ls_wdata = '0; ls_wstrb = '0;
    @(negedge clk);
    check("rmw N+1 if_ready",  {31'b0, if_ready},  32'h0);
    check("rmw N+1 ls_ready",  {31'b0, ls_ready},  32'h0);
    check("rmw N+1 mem_wen",   {31'b0, mem_wen},   32'h1);
    check("rmw N+1 mem_ren",   {31'b0, mem_ren},   32'h0);
    check("rmw N+1 mem_waddr", {16'b0, mem_waddr}, 32'h10);
    check("rmw N+1 mem_wdata", mem_wdata,          32'hAABB_EEDD);
    check("rmw N+1 ls_rvalid", {31'b0, ls_rvalid}, 32'h0);
    tick();
    @(negedge clk);
    check("rmw N+2 ls_rvalid", {31'b0, ls_rvalid}, 32'h1);
    check("rmw N+2 ls_rdata",  ls_rdata,           32'h0);
    check("rmw N+2 if_ready",  {31'b0, if_ready},  32'h1);
    check("rmw N+2 ls_ready",  {31'b0, ls_ready},  32'h0);
    check("rmw memory word",   mem[16'h10],        32'hAABB_EEDD);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check("rmw N+3 if_rvalid", {31'b0, if_rvalid}, 32'h1);
    check("rmw N+3 if_rdata",  if_rdata,           32'hDEAD_BEEF);
    check("rmw N+3 ls_ready",  {31'b0, ls_ready},  32'h1);
    tick();
    ls_req = 1'b0;
    @(negedge clk);
    check("rmw N+4 ls_rdata",  ls_rdata,           32'h2222_2222);
    tick();

    // Contention from reset: round-robin alternates LS first; priority instance always LS.
    apply_reset();
    if_req = 1'b1; if_addr = 32'h14;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rr c%0d if_ready", k), {31'b0, if_ready}, (k % 2 == 1) ? 32'h1 : 32'h0);
      check($sformatf("rr c%0d ls_ready", k), {31'b0, ls_ready}, (k % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("prio c%0d ls_ready", k), {31'b0, p1_ls_ready}, 32'h1);
      check($sformatf("prio c%0d if_ready", k), {31'b0, p1_if_ready}, 32'h0);
      if (k > 0) begin
        check($sformatf("rr c%0d ls_rvalid", k), {31'b0, ls_rvalid}, (k % 2 == 1) ? 32'h1 : 32'h0);
        check($sformatf("rr c%0d if_rvalid", k), {31'b0, if_rvalid}, (k % 2 == 0) ? 32'h1 : 32'h0);
      end
      tick();
    end
    clear_inputs();
    tick();

    // Reset during the RMW write cycle must drop the write and its acknowledge.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h1100_0000; ls_wstrb = 4'b1000;
    @(negedge clk);
    check("rstrmw ls_ready", {31'b0, ls_ready}, 32'h1);
    tick();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    check("rstrmw mem_wen",   {31'b0, mem_wen},   32'h0);
    check("rstrmw ls_rvalid", {31'b0, ls_rvalid}, 32'h0);
    tick();
    @(negedge clk);
    check("rstrmw ls_rvalid 2", {31'b0, ls_rvalid}, 32'h0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rstrmw ls_rvalid 3", {31'b0, ls_rvalid}, 32'h0);
    check("rstrmw word kept",   mem[16'h10],        32'hAABB_EEDD);
    tick();
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    check("post rst if_ready", {31'b0, if_ready}, 32'h1);
    check("post rst mem_wen",  {31'b0, mem_wen},  32'h0);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check("post rst if_rvalid", {31'b0, if_rvalid}, 32'h1);
    check("post rst if_rdata",  if_rdata,           32'hAABB_EEDD);
    check("post rst ls_rvalid", {31'b0, ls_rvalid}, 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
